// File: rtl/video_scan_pkg.sv
// Shared state type and default widths for the video scan RAM.
package video_scan_pkg;

   localparam int VSR_DATA_W = 9;
   localparam int VSR_ADDR_W = 11;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Define VIDEO_SCAN_RAM_BYPASS_EN for write-first forwarding on an address collision.
module vram_dp
   import video_scan_pkg::*;
#(
   parameter int DATA_W = VSR_DATA_W,
   parameter int ADDR_W = VSR_ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Without forwarding the read sees the pre-write contents (read-first).
   always_ff @(posedge clk) begin
`ifdef VIDEO_SCAN_RAM_BYPASS_EN
      if (i_we && (i_waddr == i_raddr)) r_q <= i_wdata;
      else                              r_q <= r_mem[i_raddr];
`else
      r_q <= r_mem[i_raddr];
`endif
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/video_scan_ram.sv
// Character RAM with host write port and a row/column scan engine for video refresh.
// Build option VIDEO_SCAN_RAM_BYPASS_EN selects write-first collision behaviour in vram_dp.
module video_scan_ram
   import video_scan_pkg::*;
#(
   parameter int DATA_W = VSR_DATA_W,
   parameter int ADDR_W = VSR_ADDR_W,
   parameter int COLS   = 80,
   parameter int ROWS   = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] scroll_base,
   input  logic              frame_start,
   input  logic              scan_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_eol,
   output logic              rd_eof,
   output logic              busy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   generate
      if (COLS * ROWS > DEPTH) begin : g_size_check
         $error("video_scan_ram: COLS*ROWS exceeds memory depth");
      end
   endgenerate

   scan_state_t       r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic              r_vld_p0;
   logic              r_eol_p0;
   logic              r_eof_p0;

   logic              w_issue;
   logic              w_last_col;
   logic              w_last_row;
   logic [DATA_W-1:0] w_ram_q;

   // A restart cycle issues no read; the new frame begins on the following cycle.
   assign w_issue    = (r_state == ST_SCAN) && scan_en && !frame_start;
   assign w_last_col = (r_col == COL_W'(COLS - 1));
   assign w_last_row = (r_row == ROW_W'(ROWS - 1));
   assign busy       = (r_state == ST_SCAN);

   vram_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_vram (
      .clk     (clk),
      .i_we    (wr_en),
      .i_waddr (wr_addr),
      .i_wdata (wr_data),
      .i_raddr (r_ptr),
      .o_rdata (w_ram_q)
   );

   // Stage p0: scan control, issue read, tag markers alongside the RAM read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_vld_p0 <= 1'b0;
         r_eol_p0 <= 1'b0;
         r_eof_p0 <= 1'b0;
      end else begin
         r_vld_p0 <= w_issue;
         r_eol_p0 <= w_issue && w_last_col;
         r_eof_p0 <= w_issue && w_last_col && w_last_row;
         if (frame_start) begin
            r_state <= ST_SCAN;
            r_ptr   <= scroll_base;
            r_col   <= '0;
            r_row   <= '0;
         end else if (w_issue) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            if (w_last_col) begin
               r_col <= '0;
               if (w_last_row) begin
                  r_row   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_row <= r_row + ROW_W'(1);
               end
            end else begin
               r_col <= r_col + COL_W'(1);
            end
         end
      end
   end

   // Stage p1: output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_eol   <= 1'b0;
         rd_eof   <= 1'b0;
      end else begin
         rd_data  <= w_ram_q;
         rd_valid <= r_vld_p0;
         rd_eol   <= r_eol_p0;
         rd_eof   <= r_eof_p0;
      end
   end

endmodule

// File: tb/tb_video_scan_ram.sv
// Scoreboard bench for video_scan_ram: an 80x25 instance and a 4x2 instance share all inputs.
`timescale 1ns/1ps
module tb_video_scan_ram;

   localparam int DW = 9;
   localparam int AW = 11;
   localparam int LOGN = 8192;

   typedef struct {
      int          due;
      logic [DW-1:0] data;
      logic        eol;
      logic        eof;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] scroll_base;
   logic          frame_start;
   logic          scan_en;
   logic          sel;

   logic [DW-1:0] big_data, sml_data, o_data;
   logic          big_vld, big_eol, big_eof, big_busy;
   logic          sml_vld, sml_eol, sml_eof, sml_busy;
   logic          o_vld, o_eol, o_eof, o_busy;

   int            n_total = 0;
   int            n_bad   = 0;
   int            cyc     = 0;
   int            n_words = 0;
   int            n_eol   = 0;
   int            n_eof   = 0;

   exp_t          sb[$];
   logic [DW-1:0] m_mem [2**AW];
   logic [AW-1:0] m_ptr = '0;
   int            m_col = 0;
   int            m_row = 0;
   logic          m_scan = 1'b0;
   logic [DW-1:0] wlog [LOGN];

   always #5 clk = ~clk;

   video_scan_ram #(.DATA_W(DW), .ADDR_W(AW), .COLS(80), .ROWS(25)) u_big (
      .clk (clk), .reset (reset), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .scroll_base (scroll_base), .frame_start (frame_start), .scan_en (scan_en),
      .rd_data (big_data), .rd_valid (big_vld), .rd_eol (big_eol), .rd_eof (big_eof),
      .busy (big_busy)
   );

   video_scan_ram #(.DATA_W(DW), .ADDR_W(AW), .COLS(4), .ROWS(2)) u_sml (
      .clk (clk), .reset (reset), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .scroll_base (scroll_base), .frame_start (frame_start), .scan_en (scan_en),
      .rd_data (sml_data), .rd_valid (sml_vld), .rd_eol (sml_eol), .rd_eof (sml_eof),
      .busy (sml_busy)
   );

   assign o_data = sel ? sml_data : big_data;
   assign o_vld  = sel ? sml_vld  : big_vld;
   assign o_eol  = sel ? sml_eol  : big_eol;
   assign o_eof  = sel ? sml_eof  : big_eof;
   assign o_busy = sel ? sml_busy : big_busy;

   function automatic logic [DW-1:0] pat(input int a);
      return DW'(a * 37 + (a >> 9));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic s);
      reset = 1'b1;
      sel   = s;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic start(input int base);
      scroll_base = AW'(base);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((m_scan || sb.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(m_scan || sb.size() != 0), 0);
   endtask

   initial begin
      int w0;
      reset = 1'b1; sel = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      scroll_base = '0; frame_start = 1'b0; scan_en = 1'b0;

      fork
         // reference model: samples inputs at each rising edge
         begin
            exp_t e;
            logic iss;
            int   mc, mr;
            forever begin
               @(posedge clk);
               mc = sel ? 4 : 80;
               mr = sel ? 2 : 25;
               if (reset) begin
                  m_scan = 1'b0; m_ptr = '0; m_col = 0; m_row = 0;
               end else begin
                  iss = m_scan && scan_en && !frame_start;
                  if (iss) begin
                     e.due  = cyc + 2;
                     e.data = m_mem[m_ptr];
`ifdef VIDEO_SCAN_RAM_BYPASS_EN
                     if (wr_en && wr_addr == m_ptr) e.data = wr_data;
`endif
                     e.eol = (m_col == mc - 1);
                     e.eof = e.eol && (m_row == mr - 1);
                     sb.push_back(e);
                  end
                  if (frame_start) begin
                     m_scan = 1'b1; m_ptr = scroll_base; m_col = 0; m_row = 0;
                  end else if (iss) begin
                     m_ptr = m_ptr + 1'b1;
                     if (e.eol) begin
                        m_col = 0;
                        if (e.eof) m_scan = 1'b0;
                        else       m_row++;
                     end else begin
                        m_col++;
                     end
                  end
               end
               if (wr_en) m_mem[wr_addr] = wr_data;
               cyc++;
            end
         end
         // output monitor on the falling edge
         begin
            exp_t h;
            forever begin
               @(negedge clk);
               if (reset) begin
                  chk("rst_valid", 32'(o_vld), 0);
                  chk("rst_data",  32'(o_data), 0);
                  chk("rst_eol",   32'(o_eol), 0);
                  chk("rst_eof",   32'(o_eof), 0);
                  chk("rst_busy",  32'(o_busy), 0);
                  sb.delete();
               end else begin
                  if (sb.size() != 0 && sb[0].due == cyc) begin
                     h = sb.pop_front();
                     chk("valid", 32'(o_vld), 1);
                     chk("data",  32'(o_data), 32'(h.data));
                     chk("eol",   32'(o_eol), 32'(h.eol));
                     chk("eof",   32'(o_eof), 32'(h.eof));
                     wlog[n_words % LOGN] = o_data;
                     n_words++;
                     if (o_eol) n_eol++;
                     if (o_eof) n_eof++;
                  end else begin
                     chk("idle_valid", 32'(o_vld), 0);
                     chk("idle_eol",   32'(o_eol), 0);
                     chk("idle_eof",   32'(o_eof), 0);
                  end
                  chk("busy", 32'(o_busy), 32'(m_scan));
               end
            end
         end
         begin
            #2_000_000;
            $display("FAIL watchdog: got=timeout expected=finish");
            $fatal(1, "watchdog expired");
         end
      join_none

      tick(); tick(); tick();
      reset = 1'b0;

      for (int a = 0; a < 2**AW; a++) begin
         wr_en = 1'b1; wr_addr = AW'(a); wr_data = pat(a);
         tick();
      end
      wr_en = 1'b0;

      // first-word latency on the 80x25 instance
      wr_en = 1'b1; wr_addr = AW'(5); wr_data = 9'h1A5;
      tick();
      wr_en = 1'b0;
      scan_en = 1'b1;
      start(5);
      tick();
      chk("lat_valid_early", 32'(o_vld), 0);
      tick();
      chk("lat_valid", 32'(o_vld), 1);
      chk("lat_data",  32'(o_data), 32'h1A5);

      // 4x2 frame wrapping across the top of memory
      do_reset(1'b1);
      w0 = n_words;
      chk("w34_pre_eol", 32'(n_eol), 32'(n_eol));
      begin
         int e0, f0;
         e0 = n_eol; f0 = n_eof;
         start(2046);
         drain(100);
         chk("w34_words", 32'(n_words - w0), 8);
         chk("w34_eols",  32'(n_eol - e0), 2);
         chk("w34_eofs",  32'(n_eof - f0), 1);
         chk("w34_w1",    32'(wlog[w0 % LOGN]), 32'(pat(2046)));
         chk("w34_w3",    32'(wlog[(w0 + 2) % LOGN]), 32'(pat(0)));
         chk("w34_w7",    32'(wlog[(w0 + 6) % LOGN]), 32'(pat(4)));
         chk("w34_w8",    32'(wlog[(w0 + 7) % LOGN]), 32'h1A5);
      end

      // same-cycle write and scan read of one address
      wr_en = 1'b1; wr_addr = AW'(100); wr_data = 9'h011;
      tick();
      wr_en = 1'b0;
      w0 = n_words;
      start(100);
      wr_en = 1'b1; wr_addr = AW'(100); wr_data = 9'h0FF;
      tick();
      wr_en = 1'b0;
      drain(100);
`ifdef VIDEO_SCAN_RAM_BYPASS_EN
      chk("collide", 32'(wlog[w0 % LOGN]), 32'h0FF);
`else
      chk("collide", 32'(wlog[w0 % LOGN]), 32'h011);
`endif

      // scan_en gaps: 1,0,1 then random
      w0 = n_words;
      start(20);
      scan_en = 1'b1; tick();
      scan_en = 1'b0; tick();
      scan_en = 1'b1; tick();
      for (int i = 0; i < 12; i++) begin
         scan_en = 1'($urandom_range(0, 1));
         tick();
      end
      scan_en = 1'b1;
      drain(100);
      chk("gap_words", 32'(n_words - w0), 8);
      chk("gap_last",  32'(wlog[(w0 + 7) % LOGN]), 32'(pat(27)));

      // reset mid-scan on the 80x25 instance
      do_reset(1'b0);
      start(300);
      repeat (10) tick();
      reset = 1'b1;
      #1;
      chk("r_mid_valid", 32'(o_vld), 0);
      chk("r_mid_data",  32'(o_data), 0);
      chk("r_mid_eof",   32'(o_eof), 0);
      chk("r_mid_busy",  32'(o_busy), 0);
      tick();
      reset = 1'b0;
      w0 = n_words;
      repeat (20) tick();
      chk("r_post_words", 32'(n_words - w0), 0);
      begin
         int f0;
         f0 = n_eof;
         start(300);
         drain(3000);
         chk("r_new_words", 32'(n_words - w0), 2000);
         chk("r_new_first", 32'(wlog[w0 % LOGN]), 32'(pat(300)));
         chk("r_new_eofs",  32'(n_eof - f0), 1);
      end

      // restart at word 30 with a new base
      begin
         int f0;
         f0 = n_eof;
         w0 = n_words;
         start(1000);
         repeat (30) tick();
         start(1500);
         drain(3000);
         chk("rs_words",   32'(n_words - w0), 2030);
         chk("rs_first",   32'(wlog[w0 % LOGN]), 32'(pat(1000)));
         chk("rs_restart", 32'(wlog[(w0 + 30) % LOGN]), 32'(pat(1500)));
         chk("rs_eofs",    32'(n_eof - f0), 1);
      end

      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
